bsub_serial: RTL



---
 rtl/bsub_serial_pkg.sv | 21 ++
 rtl/bsub_serial_bgen_cell.sv | 19 +
 rtl/bsub_serial.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bsub_serial_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bsub_pkg
// Purpose  : Shared state encoding and counter sizing for bsub_serial.
// Revision : 1.0 - initial release
// ============================================================================
package bsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bsub_state_t;

    // Bit-counter width; a one-bit counter is kept as the floor.
    function automatic int bsub_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : bsub_pkg
`default_nettype wire

// File: rtl/bsub_serial_bgen_cell.sv
`default_nettype none
// ============================================================================
// Module   : bgen_cell
// Purpose  : Combinational one-bit borrow/difference cell (full subtractor).
// Revision : 1.0 - initial release
// ============================================================================
module bgen_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : bgen_cell
`default_nettype wire

// File: rtl/bsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : bsub_serial
// Purpose  : Bit-serial a - b, LSB first, one bit per clock through a single
//            registered borrow, with valid/ready handshakes on both sides.
//            Define BSUB_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module bsub_serial
    import bsub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef BSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = bsub_cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

    bsub_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             w_d;
    logic             w_bout;

`ifdef BSUB_OVF_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    bgen_cell u_bgen_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .d    (w_d),
        .bout (w_bout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        brw_d     = brw_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef BSUB_OVF_EN
        amsb_d    = amsb_q;
        bmsb_d    = bmsb_q;
        ovf_d     = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SHIFT;
                    a_d     = a;
                    b_d     = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
`ifdef BSUB_OVF_EN
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                end
            end

            SHIFT: begin
                // Result fills from the top so it lands in natural order after WIDTH shifts.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {w_d, res_q[WIDTH-1:1]};
                brw_d = w_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_LAST_BIT) begin
                    state_d = DONE;
`ifdef BSUB_OVF_EN
                    ovf_d   = (amsb_q != bmsb_q) && (w_d != amsb_q);
`endif
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BSUB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = (state_q == DONE) && ovf_q;
`endif

    // Partial results and the running borrow stay hidden until the result is complete.
    assign diff       = (state_q == DONE) ? res_q : '0;
    assign borrow_out = (state_q == DONE) && brw_q;

endmodule : bsub_serial
`default_nettype wire
